// File: rtl/mem_arb_if.sv
// Round-robin arbiter feeding NUM_CH load/store requesters onto one memory port,
// one transaction in flight, with a per-transaction response timeout.
module mem_arb_if #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_load,
  input  logic [NUM_CH-1:0]          ch_store,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_err,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       busy,
  output logic                       cs,
  output logic                       read_req,
  output logic                       write_req,
  output logic [ADDR_W-1:0]          addrout,
  output logic [DATA_W-1:0]          datatomem,
  input  logic [DATA_W-1:0]          datafrommem,
  input  logic                       mem_resp
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       last_grant;
  logic [CW-1:0]       grant;
  logic [CW-1:0]       pick;
  logic [CW-1:0]       cand;
  logic                found;
  logic                op_store;
  logic [15:0]         tmo_cnt;
  logic [NUM_CH-1:0]   req_vec;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  int                  idx;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign req_vec = ch_load | ch_store;
  assign busy    = (state != IDLE);

  // Search upward from the channel after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    cand  = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      idx  = (int'(last_grant) + off) % NUM_CH;
      cand = CW'(idx);
      if (!found && req_vec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick == CW'(c)) begin
        addr_sel  = ch_addr[c*ADDR_W +: ADDR_W];
        wdata_sel = ch_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CW'(NUM_CH - 1);
      grant      <= '0;
      op_store   <= 1'b0;
      tmo_cnt    <= '0;
      ch_done    <= '0;
      ch_err     <= '0;
      ch_rdata   <= '0;
      cs         <= 1'b0;
      read_req   <= 1'b0;
      write_req  <= 1'b0;
      addrout    <= '0;
      datatomem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            if (ch_load[pick] && ch_store[pick]) begin
              // Conflicting op request: report the error without touching memory.
              state    <= DONE;
              ch_done  <= onehot(pick);
              ch_err   <= onehot(pick);
              ch_rdata <= '0;
            end else begin
              state     <= REQ;
              op_store  <= ch_store[pick];
              cs        <= 1'b1;
              read_req  <= ch_load[pick];
              write_req <= ch_store[pick];
              addrout   <= addr_sel;
              tmo_cnt   <= '0;
              if (ch_store[pick])
                datatomem <= wdata_sel;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          // A response in the timeout cycle still counts as success.
          if (mem_resp) begin
            state     <= DONE;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            ch_done   <= onehot(grant);
            ch_err    <= '0;
            ch_rdata  <= op_store ? '0 : datafrommem;
          end else if ((tmo_cnt + 16'd1) == 16'(TIMEOUT)) begin
            state     <= DONE;
            cs        <= 1'b0;
            read_req  <= 1'b0;
            write_req <= 1'b0;
            ch_done   <= onehot(grant);
            ch_err    <= onehot(grant);
            ch_rdata  <= '0;
          end
        end
        DONE: begin
          state      <= IDLE;
          ch_done    <= '0;
          ch_err     <= '0;
          ch_rdata   <= '0;
          last_grant <= grant;
          tmo_cnt    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_if.sv
// Directed bench for mem_arb_if: two channels, short timeout, hand-computed expectations.
module tb_mem_arb_if;

  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 4;

  logic                      clk;
  logic                      reset;
  logic [NUM_CH-1:0]         ch_load;
  logic [NUM_CH-1:0]         ch_store;
  logic [NUM_CH*ADDR_W-1:0]  ch_addr;
  logic [NUM_CH*DATA_W-1:0]  ch_wdata;
  logic [NUM_CH-1:0]         ch_done;
  logic [NUM_CH-1:0]         ch_err;
  logic [DATA_W-1:0]         ch_rdata;
  logic                      busy;
  logic                      cs;
  logic                      read_req;
  logic                      write_req;
  logic [ADDR_W-1:0]         addrout;
  logic [DATA_W-1:0]         datatomem;
  logic [DATA_W-1:0]         datafrommem;
  logic                      mem_resp;

  int total = 0;
  int bad   = 0;

  mem_arb_if #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .ch_load(ch_load), .ch_store(ch_store), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_err(ch_err), .ch_rdata(ch_rdata), .busy(busy),
    .cs(cs), .read_req(read_req), .write_req(write_req), .addrout(addrout),
    .datatomem(datatomem), .datafrommem(datafrommem), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int               nd;
  int               ncs;
  logic [NUM_CH-1:0] seq [4];

  initial begin
    reset       = 1'b1;
    ch_load     = '0;
    ch_store    = '0;
    ch_addr     = '0;
    ch_wdata    = '0;
    datafrommem = '0;
    mem_resp    = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_cs",    cs,        0);
    chk("rst_busy",  busy,      0);
    chk("rst_done",  ch_done,   0);
    chk("rst_rd",    read_req,  0);
    chk("rst_wr",    write_req, 0);
    chk("rst_addr",  addrout,   0);

    // Single load on ch0, response two cycles after read_req.
    ch_load = 2'b01;
    ch_addr[0 +: ADDR_W] = 14'h0123;
    step();
    chk("ld_cs1",   cs,        1);
    chk("ld_rd1",   read_req,  1);
    chk("ld_wr1",   write_req, 0);
    chk("ld_addr",  addrout,   14'h0123);
    chk("ld_busy",  busy,      1);
    step();
    chk("ld_cs2",   cs,        1);
    step();
    chk("ld_cs3",   cs,        1);
    mem_resp    = 1'b1;
    datafrommem = 16'hBEEF;
    step();
    chk("ld_done",  ch_done,   2'b01);
    chk("ld_rdata", ch_rdata,  16'hBEEF);
    chk("ld_err",   ch_err,    0);
    chk("ld_cs4",   cs,        0);
    ch_load  = '0;
    mem_resp = 1'b0;
    step();
    chk("ld_idle",  busy,      0);
    chk("ld_done0", ch_done,   0);

    // Store on ch1, immediate response.
    ch_store = 2'b10;
    ch_addr  = {14'h3FFF, 14'h0000};
    ch_wdata = {16'hA5A5, 16'h0000};
    datafrommem = 16'h1234;
    step();
    chk("st_cs",    cs,        1);
    chk("st_wr",    write_req, 1);
    chk("st_rd",    read_req,  0);
    chk("st_data",  datatomem, 16'hA5A5);
    chk("st_addr",  addrout,   14'h3FFF);
    mem_resp = 1'b1;
    step();
    chk("st_done",  ch_done,   2'b10);
    chk("st_rdata", ch_rdata,  0);
    chk("st_err",   ch_err,    0);
    ch_store = '0;
    mem_resp = 1'b0;
    step();

    // Both channels requesting continuously with instant response.
    ch_load  = 2'b11;
    ch_addr  = {14'h0222, 14'h0111};
    mem_resp = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ch_done != '0) begin
        if (nd < 4) seq[nd] = ch_done;
        nd++;
        chk("rr_err", ch_err, 0);
      end
    end
    chk("rr_count", nd,     4);
    chk("rr_g0",    seq[0], 2'b01);
    chk("rr_g1",    seq[1], 2'b10);
    chk("rr_g2",    seq[2], 2'b01);
    chk("rr_g3",    seq[3], 2'b10);
    ch_load  = '0;
    mem_resp = 1'b0;
    step();

    // Timeout: ch0 load, memory never answers.
    ch_load = 2'b01;
    step();
    ncs = 0;
    for (int i = 0; i < 20 && cs; i++) begin
      ncs++;
      step();
    end
    chk("to_cycles", ncs,     4);
    chk("to_done",   ch_done, 2'b01);
    chk("to_err",    ch_err,  2'b01);
    chk("to_rdata",  ch_rdata, 0);
    ch_load = '0;
    step();
    // Next request after the timeout completes normally.
    ch_store = 2'b10;
    ch_wdata = {16'h5A5A, 16'h0000};
    step();
    chk("to2_wr",   write_req, 1);
    chk("to2_data", datatomem, 16'h5A5A);
    mem_resp = 1'b1;
    step();
    chk("to2_done", ch_done, 2'b10);
    chk("to2_err",  ch_err,  0);
    ch_store = '0;
    mem_resp = 1'b0;
    step();

    // Load and store together on ch0: error without any memory access.
    ch_load  = 2'b01;
    ch_store = 2'b01;
    step();
    chk("il_cs",   cs,      0);
    chk("il_done", ch_done, 2'b01);
    chk("il_err",  ch_err,  2'b01);
    chk("il_busy", busy,    1);
    ch_load  = '0;
    ch_store = '0;
    step();
    chk("il_idle", busy,    0);

    // Reset in the middle of a ch1 load.
    ch_load = 2'b10;
    step();
    chk("mr_cs_pre", cs, 1);
    #3 reset = 1'b1;
    #1;
    chk("mr_cs",   cs,       0);
    chk("mr_rd",   read_req, 0);
    chk("mr_busy", busy,     0);
    chk("mr_done", ch_done,  0);
    ch_load = '0;
    step();
    reset = 1'b0;
    step();
    chk("mr_done2", ch_done, 0);
    ch_load  = 2'b11;
    ch_addr  = {14'h0222, 14'h0111};
    mem_resp = 1'b1;
    step();
    chk("mr_addr",  addrout, 14'h0111);
    step();
    chk("mr_first", ch_done, 2'b01);
    ch_load  = '0;
    mem_resp = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arb_if.md
Name: mem_arb_if

Overview:
- Parametrised successor to the single-requester memory interface unit.
- Arbitrates load/store requests from NUM_CH requester channels (instruction units, DMA, etc.) onto one external memory port.
- Uses round-robin grant, one outstanding transaction at a time, and a per-transaction response timeout that reports an error to the requester.
- Sits between the requesters and the memory bus pins (cs, read_req, write_req, addrout, datatomem, datafrommem, mem_resp).

Parameters:
- NUM_CH, 2, number of requester channels (2..8).
- DATA_W, 16, memory data width.
- ADDR_W, 14, memory address width.
- TIMEOUT, 255, max cycles waiting for mem_resp before abort (1..65535).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous reset, active-high.
- ch_load  in  NUM_CH  per-channel load request (level).
- ch_store  in  NUM_CH  per-channel store request (level).
- ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  packed store data, same packing.
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel.
- ch_err  out  NUM_CH  one-cycle error pulse, coincident with ch_done.
- ch_rdata  out  DATA_W  load data, valid in the ch_done cycle.
- busy  out  1  high whenever state != IDLE.
- cs  out  1  memory chip select.
- read_req  out  1  memory read strobe.
- write_req  out  1  memory write strobe.
- addrout  out  ADDR_W  memory address.
- datatomem  out  DATA_W  memory write data.
- datafrommem  in  DATA_W  memory read data.
- mem_resp  in  1  memory acknowledge, sampled only in REQ.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; timeout counter 0; last-grant pointer = NUM_CH-1, so channel 0 wins first.
- Requests: channel i requests when ch_load[i] | ch_store[i]. The requester holds the request until its ch_done, then deasserts. A request still high in the cycle after ch_done is treated as a new request.
- States: IDLE, REQ, DONE.
- IDLE:
  - If any request, grant the first requesting channel searching upward (wrapping) from last-grant+1.
  - Latch grant id, op, ch_addr slice and ch_wdata slice; go REQ.
  - With no request, stay.
- Illegal request (ch_load[i] and ch_store[i] both high at grant): no memory access; go straight to DONE with ch_err[i]=1.
- REQ:
  - Registered outputs cs=1, addrout=latched addr, and read_req=1 (load) or write_req=1 plus datatomem=latched data (store). The strobe matching the other op stays 0.
  - Outputs are held stable for the whole of REQ.
  - Timeout counter increments each REQ cycle.
  - mem_resp=1: latch datafrommem (loads only); go DONE.
  - Counter reaches TIMEOUT with mem_resp=0: go DONE with error flag set.
  - mem_resp and timeout in the same cycle: mem_resp wins, no error.
- DONE (exactly one cycle):
  - cs/read_req/write_req=0.
  - ch_done[g]=1; ch_err[g]=error flag; ch_rdata=latched load data. ch_rdata is 0 for stores and errors.
  - last-grant pointer = g; counter cleared; go IDLE.
- Latency:
  - Request seen in cycle 0 → cs/strobe high in cycle 1.
  - mem_resp sampled high in cycle k → ch_done in cycle k+1 → IDLE in cycle k+2.
  - Minimum 3 cycles per transaction.
- Request inputs are ignored outside IDLE. A request changing during a transaction has no effect on it.
- mem_resp outside REQ is ignored.
- datatomem and addrout may hold stale values outside REQ. cs gates their validity.
- At most one ch_done bit is high in any cycle.
- Reset mid-REQ: strobes drop immediately; the transaction is lost and no ch_done is issued.

Test Plan:
- Single load ch0 at addr 0x0123; memory returns 0xBEEF with mem_resp 2 cycles after read_req → cs/read_req high cycles 1-3, addrout=0x0123, ch_done[0] and ch_rdata=0xBEEF in cycle 4, ch_err=0.
- Store ch1, addr 0x3FFF, data 0xA5A5, mem_resp immediately → write_req=1, datatomem=0xA5A5, read_req=0, ch_done[1] one cycle after mem_resp, ch_rdata=0.
- ch0 and ch1 requesting continuously (NUM_CH=2), instant mem_resp → grants alternate 0,1,0,1; no channel is granted twice in a row; 4 done pulses in 12 cycles.
- TIMEOUT=4, mem_resp never asserted → strobes drop after 4 REQ cycles; ch_done[g]=ch_err[g]=1; next request proceeds normally.
- ch_load[0] and ch_store[0] both high → no cs assertion; ch_done[0]=ch_err[0]=1 in cycle 1.
- reset asserted mid-REQ → cs/read_req/write_req/busy go 0 asynchronously, no ch_done; after release, channel 0 is granted first.
